// File: rtl/button_event_ctrl.sv
// Push-button front end: synchronizes and debounces the raw pin, classifies
// presses as short or long, and maintains the LED mode index.
module button_event_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter int unsigned NUM_MODES         = 5,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       btn_pressed,
    output logic       press_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic [2:0] mode,
    output logic       mode_change
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [2:0]        MODE_MAX = 3'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_t;

    state_t            state, state_next;
    logic              btn_norm;
    logic              sync1, btn_sync;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_toggle, rise_evt, fall_evt;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              press_next, short_next, long_next;
    logic [2:0]        mode_d;

    assign btn_norm = BTN_ACTIVE_LOW ? ~button : button;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn_norm;
            btn_sync <= sync1;
        end
    end

    // Debounced edges are decoded from the toggle condition so the FSM and its
    // pulses react on the same edge that btn_pressed itself changes.
    assign deb_toggle = (btn_sync != btn_pressed) && (deb_cnt == DEB_MAX);
    assign rise_evt   = deb_toggle && !btn_pressed;
    assign fall_evt   = deb_toggle && btn_pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            btn_pressed <= 1'b0;
        end else if (btn_sync == btn_pressed) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
            deb_cnt     <= '0;
            btn_pressed <= ~btn_pressed;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            press_pulse <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            press_pulse <= press_next;
            short_press <= short_next;
            long_press  <= long_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        press_next = 1'b0;
        short_next = 1'b0;
        long_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_evt) begin
                    state_next = ST_HELD;
                    press_next = 1'b1;
                    hold_next  = '0;
                end
            end
            ST_HELD: begin
                // Release takes priority over reaching the long threshold.
                if (fall_evt) begin
                    state_next = ST_IDLE;
                    short_next = 1'b1;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_next = ST_LONG;
                    long_next  = 1'b1;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (fall_evt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= '0;
            mode_d      <= '0;
            mode_change <= 1'b0;
        end else begin
            if (short_press) begin
                mode <= (mode == MODE_MAX) ? '0 : mode + 3'd1;
            end else if (long_press) begin
                mode <= '0;
            end
            mode_d      <= mode;
            mode_change <= (mode != mode_d);
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with small debounce/long thresholds.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic       btn_pressed, press_pulse, short_press, long_press, mode_change;
    logic [2:0] mode;

    int n_cmp = 0;
    int n_err = 0;

    // Sample index: cyc=k means k rising edges after the last stimulus origin.
    int cyc;
    int n_press, n_short, n_long, n_mchg, excl_viol;
    int t_bp, t_press, t_short, t_long, t_mchg;

    button_event_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .NUM_MODES        (5),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .btn_pressed(btn_pressed),
        .press_pulse(press_pulse),
        .short_press(short_press),
        .long_press (long_press),
        .mode       (mode),
        .mode_change(mode_change)
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        cyc = 0; n_press = 0; n_short = 0; n_long = 0; n_mchg = 0;
        t_bp = -1; t_press = -1; t_short = -1; t_long = -1; t_mchg = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (btn_pressed && t_bp < 0) t_bp = cyc;
        if (press_pulse) begin n_press++; if (t_press < 0) t_press = cyc; end
        if (short_press) begin n_short++; if (t_short < 0) t_short = cyc; end
        if (long_press)  begin n_long++;  if (t_long < 0)  t_long = cyc;  end
        if (mode_change) begin n_mchg++;  if (t_mchg < 0)  t_mchg = cyc;  end
        if (int'(press_pulse) + int'(short_press) + int'(long_press) > 1) excl_viol++;
    endtask

    task automatic do_press(input int unsigned hi, input int unsigned lo);
        button = 1'b1;
        repeat (hi) step();
        button = 1'b0;
        repeat (lo) step();
    endtask

    task automatic apply_reset();
        button = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        clear_mon();
    endtask

    task automatic test_reset();
        button = 1'b0;
        rst_n  = 1'b0;
        #23;
        n_cmp++;
        if ({btn_pressed, press_pulse, short_press, long_press, mode_change, mode} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {btn_pressed, press_pulse, short_press, long_press, mode_change, mode});
        end
        apply_reset();
    endtask

    task automatic test_clean_press();
        clear_mon();
        do_press(10, 15);
        n_cmp++; if (t_bp !== 6) begin n_err++; $display("FAIL clean_bp_rise: got %0d expected 6", t_bp); end
        n_cmp++; if (n_press !== 1 || t_press !== 6) begin n_err++; $display("FAIL clean_press_pulse: got n=%0d t=%0d expected n=1 t=6", n_press, t_press); end
        n_cmp++; if (n_short !== 1 || t_short !== 16) begin n_err++; $display("FAIL clean_short: got n=%0d t=%0d expected n=1 t=16", n_short, t_short); end
        n_cmp++; if (n_long !== 0) begin n_err++; $display("FAIL clean_no_long: got %0d expected 0", n_long); end
        n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL clean_mode: got %0d expected 1", mode); end
        n_cmp++; if (n_mchg !== 1 || t_mchg !== 18) begin n_err++; $display("FAIL clean_mode_change: got n=%0d t=%0d expected n=1 t=18", n_mchg, t_mchg); end
    endtask

    task automatic test_bounce();
        clear_mon();
        for (int i = 0; i < 12; i++) begin
            button = (i % 2 == 0);
            step();
        end
        button = 1'b0;
        repeat (20) step();
        n_cmp++; if (t_bp !== -1) begin n_err++; $display("FAIL bounce_bp: got rise at %0d expected none", t_bp); end
        n_cmp++; if (n_press + n_short + n_long !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", n_press + n_short + n_long); end
        n_cmp++; if (mode !== 3'd1 || n_mchg !== 0) begin n_err++; $display("FAIL bounce_mode: got mode=%0d mchg=%0d expected mode=1 mchg=0", mode, n_mchg); end
    endtask

    task automatic test_short_sequence();
        logic [2:0] exp_mode [5];
        exp_mode = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_press(8, 12);
            n_cmp++;
            if (mode !== exp_mode[i]) begin
                n_err++;
                $display("FAIL seq_mode_%0d: got %0d expected %0d", i, mode, exp_mode[i]);
            end
        end
        n_cmp++; if (n_short !== 5 || n_mchg !== 5) begin n_err++; $display("FAIL seq_counts: got short=%0d mchg=%0d expected 5/5", n_short, n_mchg); end
    endtask

    task automatic test_long_press();
        apply_reset();
        repeat (3) do_press(8, 12);
        n_cmp++; if (mode !== 3'd3) begin n_err++; $display("FAIL long_setup_mode: got %0d expected 3", mode); end
        clear_mon();
        do_press(40, 15);
        n_cmp++; if (n_press !== 1 || t_press !== 6) begin n_err++; $display("FAIL long_press_pulse: got n=%0d t=%0d expected n=1 t=6", n_press, t_press); end
        n_cmp++; if (n_long !== 1 || t_long !== 26) begin n_err++; $display("FAIL long_pulse: got n=%0d t=%0d expected n=1 t=26", n_long, t_long); end
        n_cmp++; if (n_short !== 0) begin n_err++; $display("FAIL long_no_short: got %0d expected 0", n_short); end
        n_cmp++; if (mode !== 3'd0 || n_mchg !== 1 || t_mchg !== 28) begin n_err++; $display("FAIL long_mode: got mode=%0d mchg=%0d t=%0d expected 0/1/28", mode, n_mchg, t_mchg); end
    endtask

    task automatic test_coincide();
        clear_mon();
        do_press(20, 15);
        n_cmp++; if (n_short !== 1 || t_short !== 26) begin n_err++; $display("FAIL coincide_short: got n=%0d t=%0d expected n=1 t=26", n_short, t_short); end
        n_cmp++; if (n_long !== 0) begin n_err++; $display("FAIL coincide_no_long: got %0d expected 0", n_long); end
        n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL coincide_mode: got %0d expected 1", mode); end
        clear_mon();
        do_press(21, 15);
        n_cmp++; if (n_long !== 1 || t_long !== 26 || n_short !== 0) begin n_err++; $display("FAIL past_threshold: got long=%0d t=%0d short=%0d expected 1/26/0", n_long, t_long, n_short); end
        n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL past_threshold_mode: got %0d expected 0", mode); end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        repeat (2) do_press(8, 12);
        n_cmp++; if (mode !== 3'd2) begin n_err++; $display("FAIL midrst_setup_mode: got %0d expected 2", mode); end
        button = 1'b1;
        repeat (12) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({btn_pressed, press_pulse, short_press, long_press, mode_change, mode} !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_outputs: got %b expected 00000000",
                     {btn_pressed, press_pulse, short_press, long_press, mode_change, mode});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (10) step();
        n_cmp++; if (n_press !== 1 || t_press !== 6) begin n_err++; $display("FAIL midrst_press: got n=%0d t=%0d expected n=1 t=6", n_press, t_press); end
        n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL midrst_mode_held: got %0d expected 0", mode); end
        button = 1'b0;
        repeat (15) step();
        n_cmp++; if (n_short !== 1 || mode !== 3'd1) begin n_err++; $display("FAIL midrst_release: got short=%0d mode=%0d expected 1/1", n_short, mode); end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (excl_viol !== 0) begin n_err++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", excl_viol); end
    endtask

    initial begin
        excl_viol = 0;
        clear_mon();
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_sequence();
        test_long_press();
        test_coincide();
        test_reset_mid_hold();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
